// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: prefix/modifier codes, discard list, FSM state
// and the 13-bit queued event bundle for ps2_key_decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CTRL   = 8'h14;
  localparam logic [7:0] PS2_ALT    = 8'h11;

  // Keyboard housekeeping bytes that never form an event
  localparam int PS2_N_DISCARD = 6;
  localparam logic [8*PS2_N_DISCARD-1:0] PS2_DISCARD =
    {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [2:0] mods;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

  function automatic logic is_discard(input logic [7:0] b);
    is_discard = 1'b0;
    for (int i = 0; i < PS2_N_DISCARD; i++) begin
      if (b == PS2_DISCARD[i*8 +: 8]) is_discard = 1'b1;
    end
  endfunction

  // Held bits: [0]LShift [1]RShift [2]LCtrl [3]RCtrl [4]LAlt [5]RAlt
  function automatic logic [5:0] mod_mask(
    input logic [7:0] code,
    input logic       ext
  );
    logic [8:0] key;
    key = {ext, code};
    mod_mask = '0;
    unique case (1'b1)
      key == {1'b0, PS2_LSHIFT}: mod_mask = 6'b000001;
      key == {1'b0, PS2_RSHIFT}: mod_mask = 6'b000010;
      key == {1'b0, PS2_CTRL}:   mod_mask = 6'b000100;
      key == {1'b1, PS2_CTRL}:   mod_mask = 6'b001000;
      key == {1'b0, PS2_ALT}:    mod_mask = 6'b010000;
      key == {1'b1, PS2_ALT}:    mod_mask = 6'b100000;
      default:                   mod_mask = '0;
    endcase
  endfunction

  function automatic logic [2:0] mods_of(input logic [5:0] h);
    mods_of = {h[5] | h[4], h[3] | h[2], h[1] | h[0]};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_evt_fifo.sv
// ps2_evt_fifo: synchronous FIFO with occupancy count and
// reset-cleared storage; head is read combinationally.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs when full
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + {{AW{1'b0}}, do_push}
                  - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan decoder: E0/F0 prefix FSM, modifier tracking, event FIFO.
// Define PS2_KEY_DECODER_TYPEMATIC_FILTER_EN to drop typematic repeat makes.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk50,
  input  logic                        reset,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  input  logic                        byte_err,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic [2:0]                  evt_mods,
  output logic [2:0]                  mods,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  ps2_state_e state_q, state_d;
  logic [5:0] held_q, held_d;
  logic       ovf_q, ovf_d;
  logic       dec_hit, dec_ext, dec_brk;
  logic       byte_ok, is_pfx, suppress;
  logic       push, pop, fifo_full, fifo_empty;
  logic [5:0] mask;
  ps2_evt_t   wr_evt, head;

  assign byte_ok = byte_valid & ~byte_err;
  assign is_pfx  = (byte_data == PS2_E0) | (byte_data == PS2_F0);

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (byte_err) begin
      state_d = ST_IDLE;
    end else if (byte_valid) begin
      unique case (state_q)
        ST_IDLE, ST_GOT_F0: begin
          if (byte_data == PS2_E0)      state_d = ST_GOT_E0;
          else if (byte_data == PS2_F0) state_d = ST_GOT_F0;
          else                          state_d = ST_IDLE;
        end
        ST_GOT_E0: begin
          if (byte_data == PS2_F0)      state_d = ST_GOT_E0F0;
          else if (byte_data == PS2_E0) state_d = ST_GOT_E0;
          else                          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_hit = 1'b0;
    dec_ext = 1'b0;
    dec_brk = 1'b0;
    if (byte_ok) begin
      unique case (state_q)
        ST_IDLE: dec_hit = ~is_pfx & ~is_discard(byte_data);
        ST_GOT_E0: begin
          dec_hit = ~is_pfx;
          dec_ext = 1'b1;
        end
        ST_GOT_F0: begin
          dec_hit = ~is_pfx;
          dec_brk = 1'b1;
        end
        default: begin
          dec_hit = 1'b1;
          dec_ext = 1'b1;
          dec_brk = 1'b1;
        end
      endcase
    end
  end

`ifdef PS2_KEY_DECODER_TYPEMATIC_FILTER_EN
  logic [9:0] tm_q, tm_d;
  logic       tm_match;

  // tm_q = {ext, code, valid} of the last accepted make
  assign tm_match = tm_q[0] & (tm_q[9:1] == {dec_ext, byte_data});
  assign suppress = dec_hit & ~dec_brk & tm_match;

  always_comb begin
    tm_d = tm_q;
    if (dec_hit && !dec_brk) tm_d = {dec_ext, byte_data, 1'b1};
    else if (dec_hit && tm_match) tm_d[0] = 1'b0;
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) tm_q <= '0;
    else        tm_q <= tm_d;
  end
`else
  assign suppress = 1'b0;
`endif

  assign mask = mod_mask(byte_data, dec_ext);
  assign push = dec_hit & ~suppress;
  assign pop  = evt_ready & ~fifo_empty;

  always_comb begin
    held_d = held_q;
    if (push) held_d = dec_brk ? (held_q & ~mask) : (held_q | mask);
  end

  always_comb begin
    wr_evt.code = byte_data;
    wr_evt.ext  = dec_ext;
    wr_evt.brk  = dec_brk;
    wr_evt.mods = mods_of(held_d);
  end

  // A drop only happens when full and nothing leaves this edge
  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clk   (clk50),
    .rst_n (reset),
    .push  (push),
    .wdata (wr_evt),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;
  assign evt_mods  = head.mods;
  assign mods      = mods_of(held_q);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random bytes,
// checked each cycle against a queue-based model of the decoder.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
`ifdef PS2_KEY_DECODER_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk50;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [2:0] evt_mods;
  logic [2:0] mods;
  logic       overflow;
  logic [2:0] fifo_count;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk50      (clk50),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .evt_mods   (evt_mods),
    .mods       (mods),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference model: pending prefix flags, key-down table, event queue
  logic [12:0] mq[$];
  bit e0_m, f0_m, ovf_m, tm_v;
  int tm_key;
  bit down[512];

  function automatic logic [2:0] live();
    return {down[9'h011] | down[9'h111],
            down[9'h014] | down[9'h114],
            down[9'h012] | down[9'h059]};
  endfunction

  task automatic model_clear();
    mq.delete();
    e0_m = 0; f0_m = 0; ovf_m = 0; tm_v = 0; tm_key = 0;
    for (int i = 0; i < 512; i++) down[i] = 0;
  endtask

  task automatic emit(input logic [7:0] b, input bit x, input bit k);
    int key;
    key = (x ? 256 : 0) + int'(b);
    e0_m = 0; f0_m = 0;
    if (!k && FILT && tm_v && tm_key == key) return;
    if (!k) begin tm_v = 1; tm_key = key; end
    else if (tm_v && tm_key == key) tm_v = 0;
    down[key] = !k;
    if (mq.size() >= DEPTH) ovf_m = 1;
    else mq.push_back({b, x, k, live()});
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit pfx, disc;
    pfx = (b == 8'hE0) || (b == 8'hF0);
    disc = (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
           (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFC);
    if (e0_m && f0_m) emit(b, 1, 1);
    else if (e0_m) begin
      if (b == 8'hF0) f0_m = 1;
      else if (b != 8'hE0) emit(b, 1, 0);
    end else begin
      // plain IDLE, or F0 pending where a new prefix restarts
      if (b == 8'hE0) begin e0_m = 1; f0_m = 0; end
      else if (b == 8'hF0) f0_m = 1;
      else if (f0_m) emit(b, 0, 1);
      else if (!pfx && !disc) emit(b, 0, 0);
    end
  endtask

  always @(posedge clk50 or negedge reset) begin
    if (!reset) model_clear();
    else begin
      if (evt_ready && mq.size() > 0) void'(mq.pop_front());
      if (byte_err) begin e0_m = 0; f0_m = 0; end
      else if (byte_valid) model_byte(byte_data);
    end
  end

  always @(negedge clk50) begin
    if (reset) begin
      chk("valid", 32'(evt_valid), 32'(mq.size() != 0));
      chk("count", 32'(fifo_count), 32'(mq.size()));
      chk("mods", 32'(mods), 32'(live()));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      if (mq.size() != 0)
        chk("head", 32'({evt_code, evt_ext, evt_break, evt_mods}),
            32'(mq[0]));
    end
  end

  task automatic send(input logic [7:0] d);
    byte_valid = 1; byte_data = d;
    @(negedge clk50);
    byte_valid = 0;
  endtask

  task automatic pop_exp(input string nm, input logic [12:0] e);
    chk(nm, 32'({evt_valid, evt_code, evt_ext, evt_break, evt_mods}),
        32'({1'b1, e}));
    evt_ready = 1;
    @(negedge clk50);
    evt_ready = 0;
  endtask

  task automatic do_reset();
    #2 reset = 0;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'(0));
    chk("rst_head", 32'({evt_code, evt_ext, evt_break, evt_mods}), 32'(0));
    chk("rst_mods", 32'(mods), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    #1 reset = 1;
    @(negedge clk50);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] b;
    case ($urandom_range(11))
      0, 1:    b = 8'hE0;
      2, 3:    b = 8'hF0;
      4:       b = 8'h12;
      5:       b = 8'h59;
      6:       b = 8'h14;
      7:       b = 8'h11;
      8:       b = 8'h1C;
      9:       b = 8'hAA;
      10:      b = 8'h00;
      default: b = 8'($urandom_range(255));
    endcase
    return b;
  endfunction

  initial begin
    reset = 0; byte_valid = 0; byte_data = 0;
    byte_err = 0; evt_ready = 0;
    @(negedge clk50);
    do_reset();

    // make + break of plain key
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("peak_count", 32'(fifo_count), 32'(2));
    pop_exp("ev_1c_make", {8'h1C, 1'b0, 1'b0, 3'b000});
    pop_exp("ev_1c_brk", {8'h1C, 1'b0, 1'b1, 3'b000});

    // shift held around a key
    send(8'h12);
    chk("live_shift", 32'(mods), 32'(3'b001));
    send(8'h1C);
    chk("live_shift2", 32'(mods), 32'(3'b001));
    send(8'hF0); send(8'h12); send(8'hF0); send(8'h1C);
    pop_exp("sh_make", {8'h12, 1'b0, 1'b0, 3'b001});
    pop_exp("sh_key", {8'h1C, 1'b0, 1'b0, 3'b001});
    pop_exp("sh_brk", {8'h12, 1'b0, 1'b1, 3'b000});
    pop_exp("sh_kbrk", {8'h1C, 1'b0, 1'b1, 3'b000});

    // right ctrl with a fake shift in between
    send(8'hE0); send(8'h14);
    send(8'hE0); send(8'h12);
    chk("fake_shift", 32'(mods), 32'(3'b010));
    send(8'hE0); send(8'hF0); send(8'h14);
    pop_exp("rctl_make", {8'h14, 1'b1, 1'b0, 3'b010});
    pop_exp("fake_evt", {8'h12, 1'b1, 1'b0, 3'b010});
    pop_exp("rctl_brk", {8'h14, 1'b1, 1'b1, 3'b000});

    // error aborts a prefix
    send(8'hE0);
    byte_err = 1; @(negedge clk50); byte_err = 0;
    send(8'h1C);
    chk("err_count", 32'(fifo_count), 32'(1));
    pop_exp("err_make", {8'h1C, 1'b0, 1'b0, 3'b000});

    // reset mid-sequence discards the F0
    send(8'hF0);
    do_reset();
    send(8'h1C);
    pop_exp("rst_make", {8'h1C, 1'b0, 1'b0, 3'b000});

    // overflow at depth 4
    send(8'h15); send(8'h16); send(8'h1D);
    send(8'h24); send(8'h2D); send(8'h2C);
    chk("ovf_count", 32'(fifo_count), 32'(4));
    chk("ovf_flag", 32'(overflow), 32'(1));
    chk("ovf_head", 32'(evt_code), 32'(8'h15));
    byte_valid = 1; byte_data = 8'h35; evt_ready = 1;
    @(negedge clk50);
    byte_valid = 0; evt_ready = 0;
    chk("full_pp_count", 32'(fifo_count), 32'(4));
    pop_exp("ovf_q1", {8'h16, 1'b0, 1'b0, 3'b000});
    pop_exp("ovf_q2", {8'h1D, 1'b0, 1'b0, 3'b000});
    pop_exp("ovf_q3", {8'h24, 1'b0, 1'b0, 3'b000});
    pop_exp("ovf_q4", {8'h35, 1'b0, 1'b0, 3'b000});
    chk("ovf_sticky", 32'(overflow), 32'(1));
    do_reset();

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("tm_count", 32'(fifo_count), FILT ? 32'(1) : 32'(3));
    for (int i = 0; i < (FILT ? 1 : 3); i++)
      pop_exp("tm_make", {8'h1C, 1'b0, 1'b0, 3'b000});
    send(8'hF0); send(8'h1C); send(8'h1C);
    chk("tm_count2", 32'(fifo_count), 32'(2));
    pop_exp("tm_brk", {8'h1C, 1'b0, 1'b1, 3'b000});
    pop_exp("tm_remake", {8'h1C, 1'b0, 1'b0, 3'b000});

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if (n % 800 == 799) do_reset();
      byte_valid = ($urandom_range(99) < 60);
      byte_err   = ($urandom_range(99) < 3);
      byte_data  = pick();
      evt_ready  = ($urandom_range(99) < 45);
      @(negedge clk50);
    end
    byte_valid = 0; byte_err = 0; evt_ready = 0;
    @(negedge clk50);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised scan-code decoder for PS/2 set-2 keyboards. It consumes the byte stream from the PS/2 byte receiver, which delivers a one-cycle strobe per byte. It resolves E0/F0 prefixes into make/break events with an extended flag, tracks left/right Shift, Ctrl and Alt, and queues events in a FIFO drained by a valid/ready consumer. It replaces the single-register last-code/shift-only decoder and runs entirely on the system clock.

## Interface
- FIFO_DEPTH, 8, event queue depth; power of two, ≥2
- clk50  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- byte_valid  in  1  one-cycle strobe; byte_data valid
- byte_data  in  8  received scan byte
- byte_err  in  1  one-cycle strobe; receiver framing/parity error
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_code  out  8  key code, prefixes stripped
- evt_ext  out  1  code was E0-prefixed
- evt_break  out  1  1 = release, 0 = press
- evt_mods  out  3  {alt, ctrl, shift} after applying this event
- mods  out  3  live {alt, ctrl, shift}
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  events queued

## Operation
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. The FSM advances only on byte_valid.
- IDLE transitions:
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - 00, FF, AA, FA, EE, FC are discarded and the FSM stays in IDLE.
  - Any other byte → make event with ext=0.
- GOT_E0 transitions:
  - F0 → GOT_E0F0.
  - E0 → stay in GOT_E0.
  - Any other byte → make event with ext=1, then IDLE.
- GOT_F0 transitions:
  - E0 or F0 restarts the sequence per the IDLE rules.
  - Any other byte → break event with ext=0, then IDLE.
- GOT_E0F0: any byte → break event with ext=1, then IDLE.
- byte_err in any state: return to IDLE, no event. If byte_err and byte_valid assert in the same cycle, byte_err wins.
- Modifier tracking uses a 6-bit held vector: LShift 12, RShift 59, LCtrl 14, RCtrl E0 14, LAlt 11, RAlt E0 11.
  - A make sets the matching bit; a break clears it.
  - E0 12 and E0 59 (fake shifts) do not affect the vector.
  - Each bit of mods is the OR of its left/right pair.
- Every decoded event, including modifier events, is pushed as {code, ext, break, mods_next}.
- FIFO full:
  - Push without pop: the event is dropped and overflow is set. The held vector still updates.
  - Push with simultaneous pop: the push is accepted and the count is unchanged.
- FIFO empty: no bypass. A push and evt_ready in the same cycle do not pop.
- overflow clears only on reset.

## Timing
- Decode is combinational on the byte_valid cycle. The push, FSM update and held-vector update all occur at that clock edge.
- Latency is one cycle: evt_valid rises in the cycle after byte_valid when the FIFO was empty.
- evt_code, evt_ext, evt_break and evt_mods are read from the head entry with no added latency. They hold stable while evt_valid=1 and evt_ready=0.
- A pop occurs at any edge where evt_valid=1 and evt_ready=1.
- Reset values:
  - FSM in IDLE.
  - mods=0, overflow=0, fifo_count=0.
  - evt_valid=0; evt_code, evt_ext, evt_break and evt_mods read 0 (storage cleared).
  - Typematic tracker cleared.
- Reset mid-sequence, for example after E0 F0, discards the partial prefix. The next byte is decoded from IDLE.
- byte_valid may assert on consecutive cycles. Every byte is processed.

## Configuration
- Macro: PS2_KEY_DECODER_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds {ext, code, valid} of the last make.
  - A make equal to it while valid is suppressed: no push, mods unchanged.
  - A break of that key clears valid. Any different make replaces the register.
- Undefined: every make is pushed, including typematic repeats. The register is not built.

## Structure
- Package ps2_pkg holds:
  - Prefix constants PS2_E0 and PS2_F0.
  - Modifier codes.
  - The discard-byte list.
  - The FSM state enum.
  - The event struct (13 bits) and its width constant.
- One sub-module, ps2_evt_fifo: a synchronous FIFO parametrised by DEPTH and WIDTH, with count output and reset-cleared storage.
- Decoder FSM, modifier tracking and the typematic filter live in ps2_key_decoder.

## Test plan
- Bytes 1C; F0 1C:
  - Events {1C, ext0, make, mods 000} then {1C, ext0, break, 000}.
  - fifo_count peaks at 2 when evt_ready is held low.
- Bytes 12, 1C, F0 12, F0 1C:
  - Event mods read 001, 001, 000, 000.
  - Live mods = 001 between the shift make and the shift break.
- Bytes E0 14, then E0 F0 14:
  - {14, ext1, make, 010} then {14, ext1, break, 000}.
  - E0 12 between them leaves mods unchanged.
- Byte E0 then byte_err, then 1C:
  - One event only: {1C, ext0, make}.
  - Reset asserted after F0 followed by 1C also yields a make.
- FIFO_DEPTH=4, evt_ready low, six makes:
  - fifo_count=4, overflow=1, the first four codes are retained.
  - With a pop and a push in the same cycle at full, fifo_count stays 4.
- With PS2_KEY_DECODER_TYPEMATIC_FILTER_EN defined, bytes 1C 1C 1C F0 1C 1C:
  - Events: make, break, make.
  - With the macro undefined: five events.
